// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and pointer helper for fifo_sync_ext
// Purpose: mode selectors for the FWFT parameter and the wrapping pointer
//          increment used by the FIFO read and write pointers.
// Ports:   none (package).
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Pointers live in 0..depth-1 and wrap explicitly, so non-power-of-2
  // depths never depend on binary rollover.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_sync_ext_if.sv
// rtl/fifo_sync_ext_if.sv - push/pop/status bundle of fifo_sync_ext
// Purpose: groups the FIFO data handshake, status and error signals.
// Ports:   none; modport slave is the FIFO side, modport master the user side.
interface fifo_sync_ext_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) ();

  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic [CW-1:0]    af_level;
  logic [CW-1:0]    ae_level;
  logic             overflow;
  logic             underflow;
  logic             err_clear;

  modport slave (
    input  write_en, write_data, read_en, af_level, ae_level, err_clear,
    output read_data, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport master (
    output write_en, write_data, read_en, af_level, ae_level, err_clear,
    input  read_data, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/bram.sv
// rtl/bram.sv - simple dual-port RAM, registered read, 1-cycle latency
// Purpose: backing store for fifo_sync_ext.
// Ports:   clock; w_en/write_addr/write_data write port;
//          r_en/read_addr read port; read_data holds while r_en is low.
module bram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    write_addr,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (w_en) mem[write_addr] <= write_data;
    if (r_en) read_data <= mem[read_addr];
  end

endmodule

// File: rtl/fifo_sync_ext.sv
// rtl/fifo_sync_ext.sv - synchronous FIFO with optional FWFT output stage
// Purpose: BRAM-backed FIFO with run-time almost thresholds, occupancy and
//          sticky overflow/underflow flags.
// Ports:   clk, reset (sync, active-high); bus (fifo_sync_ext_if.slave)
//          carrying push, pop, status, thresholds and error signals.
module fifo_sync_ext
  import fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int FWFT  = FIFO_STD,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             reset,
  fifo_sync_ext_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             full, empty, push_ok, pop_ok, bram_ren;
  logic [WIDTH-1:0] bram_rdata;

  assign full    = (count_q == CW'(DEPTH));
  assign push_ok = bus.write_en && !full;
  assign pop_ok  = bus.read_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok)  wr_ptr_d = AW'(next_ptr(32'(wr_ptr_q), DEPTH));
    if (bram_ren) rd_ptr_d = AW'(next_ptr(32'(rd_ptr_q), DEPTH));
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    if (bus.write_en && full)  overflow_d  = 1'b1;
    if (bus.read_en && empty)  underflow_d = 1'b1;
    // Clearing wins over an error raised in the same cycle.
    if (bus.err_clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  bram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_bram (
    .clock      (clk),
    .w_en       (push_ok),
    .r_en       (bram_ren),
    .write_data (bus.write_data),
    .write_addr (wr_ptr_q),
    .read_addr  (rd_ptr_q),
    .read_data  (bram_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // The BRAM read register acts as the prefetch stage; out_q is the head.
    logic             pf_valid_q, pf_valid_d, out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    bram_cnt;
    logic             pf_move;

    // Words still in BRAM; a word pushed this cycle is not fetchable until
    // next cycle, which keeps read and write addresses apart.
    assign bram_cnt = count_q - CW'(pf_valid_q) - CW'(out_valid_q);
    assign pf_move  = pf_valid_q && (!out_valid_q || pop_ok);
    assign bram_ren = (bram_cnt != '0) && (!pf_valid_q || pf_move);
    assign empty    = !out_valid_q;

    always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      pf_valid_d  = pf_valid_q;
      if (pf_move) begin
        out_d       = bram_rdata;
        out_valid_d = 1'b1;
      end else if (pop_ok) begin
        out_valid_d = 1'b0;
      end
      if (bram_ren)     pf_valid_d = 1'b1;
      else if (pf_move) pf_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
        pf_valid_q  <= 1'b0;
      end else begin
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
        pf_valid_q  <= pf_valid_d;
      end
    end

    assign bus.read_data  = out_q;
    assign bus.read_valid = out_valid_q;
  end else begin : g_std
    logic             rd_pend_q, read_valid_q;
    logic [WIDTH-1:0] read_data_q;

    assign empty    = (count_q == '0);
    assign bram_ren = pop_ok;

    // BRAM output is re-registered so read_data has a reset value and holds.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_pend_q    <= 1'b0;
        read_valid_q <= 1'b0;
        read_data_q  <= '0;
      end else begin
        rd_pend_q    <= pop_ok;
        read_valid_q <= rd_pend_q;
        if (rd_pend_q) read_data_q <= bram_rdata;
      end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= bus.af_level);
  assign bus.almost_empty = (count_q <= bus.ae_level);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
